// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the iterative RV32M multiplier (seq_mul_csa).
package seq_mul_pkg;

    localparam int MUL_EXT_W = 34;
    localparam int MUL_ACC_W = 36;
    localparam int MUL_ITERS = 17;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    // Widen a 32-bit operand to the 34-bit internal width, signed or unsigned.
    function automatic logic [MUL_EXT_W-1:0] ext_operand(input logic [31:0] v, input logic sgn);
        return {{(MUL_EXT_W-32){sgn & v[31]}}, v};
    endfunction

endpackage

// File: rtl/seq_mul_csa_if.sv
// Handshake and operand bundle between issue/bypass logic, the multiplier and writeback.
interface seq_mul_csa_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [1:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] result_o;
    logic            busy_o;

    modport master (
        output flush_i, in_valid_i, op_i, rs1_i, rs2_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, busy_o
    );

    modport slave (
        input  flush_i, in_valid_i, op_i, rs1_i, rs2_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, busy_o
    );
endinterface

// File: rtl/seq_mul_csa_adder.sv
// Generic 3:2 carry-save compressor; carry_o is already aligned one bit to the left.
module seq_mul_csa_adder #(
    parameter int W = 36
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    always_comb begin
        sum_o      = a_i ^ b_i ^ c_i;
        carry_o    = '0;
        for (int i = 1; i < W; i++) begin
            carry_o[i] = (a_i[i-1] & b_i[i-1]) | (a_i[i-1] & c_i[i-1]) | (b_i[i-1] & c_i[i-1]);
        end
    end

endmodule

// File: rtl/seq_mul_ppgen.sv
// Partial-product pair for one radix-2x2 step; bit 33 of the multiplier carries negative weight.
module seq_mul_ppgen
    import seq_mul_pkg::*;
(
    input  logic [1:0]           bits_i,
    input  logic [MUL_EXT_W-1:0] mcand_i,
    input  logic [MUL_EXT_W-1:0] neg_mcand_i,
    input  logic                 last_i,
    output logic [MUL_ACC_W-1:0] pp0_o,
    output logic [MUL_ACC_W-1:0] pp1_o
);

    logic [MUL_EXT_W-1:0] pp1_src;

    always_comb begin
        pp1_src = last_i ? neg_mcand_i : mcand_i;
        pp0_o   = bits_i[0] ? {{(MUL_ACC_W-MUL_EXT_W){mcand_i[MUL_EXT_W-1]}}, mcand_i} : '0;
        pp1_o   = bits_i[1] ? {pp1_src[MUL_EXT_W-1], pp1_src, 1'b0} : '0;
    end

endmodule

// File: rtl/seq_mul_csa.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), 2 multiplier bits per cycle.
// Optional SEQ_MUL_ZERO_BYPASS_EN: a zero operand at accept skips straight to DONE with result 0.
//
// state | meaning
// IDLE  | ready to accept operands
// BUSY  | 17 carry-save iterations in progress
// DONE  | first cycle formats result; then holds out_valid_o until out_ready_i
module seq_mul_csa
    import seq_mul_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_mul_csa_if.slave   bus
);

    if (BITS_PER_CYCLE != 2) begin : g_bpc_check
        $error("seq_mul_csa supports only BITS_PER_CYCLE == 2");
    end

    mul_state_e           state_q, state_d;
    mul_op_e              op_q, op_d;
    logic [MUL_EXT_W-1:0] mcand_q, mcand_d;
    logic [MUL_EXT_W-1:0] neg_mcand_q, neg_mcand_d;
    logic [MUL_EXT_W-1:0] mplr_q, mplr_d;
    logic [MUL_ACC_W-1:0] acc_q, acc_d;
    logic [MUL_EXT_W-1:0] low_q, low_d;
    logic [4:0]           iter_q, iter_d;
    logic [XLEN-1:0]      result_q, result_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;

    logic [MUL_ACC_W-1:0] pp0, pp1, csa_sum, csa_carry, acc_sum;
    logic [MUL_EXT_W-1:0] mcand_ext, mplr_ext;
    logic [XLEN-1:0]      prod_lo, prod_hi;
    logic                 last_iter;
    logic                 unused_acc_hi;

    assign last_iter = (iter_q == 5'(MUL_ITERS - 1));

    seq_mul_ppgen u_ppgen (
        .bits_i      (mplr_q[1:0]),
        .mcand_i     (mcand_q),
        .neg_mcand_i (neg_mcand_q),
        .last_i      (last_iter),
        .pp0_o       (pp0),
        .pp1_o       (pp1)
    );

    seq_mul_csa_adder #(.W(MUL_ACC_W)) u_csa (
        .a_i     (acc_q),
        .b_i     (pp0),
        .c_i     (pp1),
        .sum_o   (csa_sum),
        .carry_o (csa_carry)
    );

    assign acc_sum = csa_sum + csa_carry;

    // After 17 steps low_q holds product[33:0] and acc_q holds product >> 34.
    assign prod_lo       = low_q[XLEN-1:0];
    assign prod_hi       = {acc_q[XLEN-3:0], low_q[MUL_EXT_W-1:MUL_EXT_W-2]};
    assign unused_acc_hi = ^acc_q[MUL_ACC_W-1:XLEN-2];

    assign mcand_ext = ext_operand(bus.rs1_i,
                                   (bus.op_i == MULH) || (bus.op_i == MULHSU));
    assign mplr_ext  = ext_operand(bus.rs2_i, bus.op_i == MULH);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mcand_d     = mcand_q;
        neg_mcand_d = neg_mcand_q;
        mplr_d      = mplr_q;
        acc_d       = acc_q;
        low_d       = low_q;
        iter_d      = iter_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    op_d        = mul_op_e'(bus.op_i);
                    mcand_d     = mcand_ext;
                    neg_mcand_d = '0 - mcand_ext;
                    mplr_d      = mplr_ext;
                    acc_d       = '0;
                    low_d       = '0;
                    iter_d      = '0;
                    state_d     = BUSY;
`ifdef SEQ_MUL_ZERO_BYPASS_EN
                    if ((bus.rs1_i == '0) || (bus.rs2_i == '0)) begin
                        state_d     = DONE;
                        result_d    = '0;
                        out_valid_d = 1'b1;
                    end
`endif
                end
            end
            BUSY: begin
                acc_d  = {{2{acc_sum[MUL_ACC_W-1]}}, acc_sum[MUL_ACC_W-1:2]};
                low_d  = {acc_sum[1:0], low_q[MUL_EXT_W-1:2]};
                mplr_d = {2'b00, mplr_q[MUL_EXT_W-1:2]};
                iter_d = iter_q + 5'd1;
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    result_d    = (op_q == MUL) ? prod_lo : prod_hi;
                    out_valid_d = 1'b1;
                end else if (bus.out_ready_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    result_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush_i) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            result_d    = '0;
        end

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= MUL;
            mcand_q     <= '0;
            neg_mcand_q <= '0;
            mplr_q      <= '0;
            acc_q       <= '0;
            low_q       <= '0;
            iter_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mcand_q     <= mcand_d;
            neg_mcand_q <= neg_mcand_d;
            mplr_q      <= mplr_d;
            acc_q       <= acc_d;
            low_q       <= low_d;
            iter_q      <= iter_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = result_q;
    assign bus.busy_o      = busy_q;

endmodule
